// File: rtl/rule_set_intersect.sv
// rule_set_intersect: intersects a SIP and a DIP rule ID set by walking both
// ascending slot lists in lockstep, one merge step per cycle, and packs the
// common IDs into out_set in ascending order.
// Optional build macro RULE_SET_FORMAT_CHECK_EN: when defined, a sticky
// out_fmt_err flags input sets whose valid IDs are not strictly ascending.
// Set format (declared [0:31]): bits [0:7] are slot valid bits, bits
// [8+3k:10+3k] hold the ID of slot k, MSB first.
module rule_set_intersect (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [0:31] sip_set,
  input  logic [0:31] dip_set,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [0:31] out_set,
  output logic        out_hit,
  output logic [2:0]  out_best_id,
  output logic        out_fmt_err
);

  typedef enum logic [1:0] {IDLE, MERGE, DONE} state_t;

  state_t      state;
  logic [0:31] sip_q, dip_q;
  logic [3:0]  i, j, k;

  logic [7:0]  sip_v, dip_v;
  logic [2:0]  sip_id [8];
  logic [2:0]  dip_id [8];
  logic        cur_sv, cur_dv;
  logic [2:0]  cur_sid, cur_did;
  logic [3:0]  i_nxt, j_nxt;
  logic        match;
  logic        merge_end;

  // Unpack the latched sets into per-slot valid bits and IDs.
  always_comb begin
    for (int s = 0; s < 8; s++) begin
      sip_v[s]  = sip_q[s];
      dip_v[s]  = dip_q[s];
      sip_id[s] = sip_q[8+3*s +: 3];
      dip_id[s] = dip_q[8+3*s +: 3];
    end
  end

  // One merge step: skip invalid slots, emit on equal IDs, else advance the smaller.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    cur_sv  = sip_v[i[2:0]];
    cur_dv  = dip_v[j[2:0]];
    cur_sid = sip_id[i[2:0]];
    cur_did = dip_id[j[2:0]];
    i_nxt   = i;
    j_nxt   = j;
    match   = 1'b0;
    if (!cur_sv || !cur_dv) begin
      if (!cur_sv) i_nxt = i + 4'd1;
      if (!cur_dv) j_nxt = j + 4'd1;
    end else if (cur_sid == cur_did) begin
      match = 1'b1;
      i_nxt = i + 4'd1;
      j_nxt = j + 4'd1;
    end else if (cur_sid < cur_did) begin
      i_nxt = i + 4'd1;
    end else begin
      j_nxt = j + 4'd1;
    end
    merge_end = (i_nxt == 4'd8) || (j_nxt == 4'd8);
  end

`ifdef RULE_SET_FORMAT_CHECK_EN
  // True when the valid IDs of a set are not strictly ascending in slot order.
  function automatic logic order_bad(input logic [0:31] set);
    logic       seen;
    logic [2:0] last;
    logic [2:0] id;
    order_bad = 1'b0;
    seen      = 1'b0;
    last      = 3'd0;
    for (int s = 0; s < 8; s++) begin
      id = set[8+3*s +: 3];
      if (set[s]) begin
        if (seen && id <= last) order_bad = 1'b1;
        seen = 1'b1;
        last = id;
      end
    end
  endfunction
`else
  assign out_fmt_err = 1'b0;
`endif

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignment so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      out_set     <= '0;
      out_hit     <= 1'b0;
      out_best_id <= 3'd0;
      sip_q       <= '0;
      dip_q       <= '0;
      i           <= 4'd0;
      j           <= 4'd0;
      k           <= 4'd0;
`ifdef RULE_SET_FORMAT_CHECK_EN
      out_fmt_err <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            sip_q       <= sip_set;
            dip_q       <= dip_set;
            i           <= 4'd0;
            j           <= 4'd0;
            k           <= 4'd0;
            out_set     <= '0;
            out_hit     <= 1'b0;
            out_best_id <= 3'd0;
            in_ready    <= 1'b0;
            state       <= MERGE;
`ifdef RULE_SET_FORMAT_CHECK_EN
            if (order_bad(sip_set) || order_bad(dip_set)) out_fmt_err <= 1'b1;
`endif
          end
        end
        MERGE: begin
          i <= i_nxt;
          j <= j_nxt;
          if (match) begin
            for (int s = 0; s < 8; s++) begin
              if (k == 4'(s)) begin
                out_set[s]          <= 1'b1;
                out_set[8+3*s +: 3] <= cur_sid;
              end
            end
            k <= k + 4'd1;
            if (k == 4'd0) begin
              out_hit     <= 1'b1;
              out_best_id <= cur_sid;
            end
          end
          if (merge_end) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rule_set_intersect.sv
// Directed bench for rule_set_intersect. Sets are written as {valid[0:7],
// id0..id7} so the slot-0 valid bit is the leftmost character.
module tb_rule_set_intersect;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [0:31] sip_set, dip_set;
  logic        out_valid;
  logic        out_ready;
  logic [0:31] out_set;
  logic        out_hit;
  logic [2:0]  out_best_id;
  logic        out_fmt_err;

  int n_checks = 0;
  int n_fail   = 0;

  rule_set_intersect dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .sip_set     (sip_set),
    .dip_set     (dip_set),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_set     (out_set),
    .out_hit     (out_hit),
    .out_best_id (out_best_id),
    .out_fmt_err (out_fmt_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [7:0] v, input logic [23:0] ids);
    return {v, ids};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send(input logic [31:0] s, input logic [31:0] d);
    @(negedge clk);
    check("send_in_ready", in_ready, 1'b1);
    sip_set  = s;
    dip_set  = d;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Counts cycles from acceptance until out_valid is seen (bounded).
  task automatic wait_out(input string tag, input int exp_cnt);
    int   cnt;
    logic got;
    cnt = 0;
    got = 1'b0;
    while (!got && cnt < 40) begin
      @(posedge clk);
      cnt++;
      @(negedge clk);
      got = out_valid;
    end
    check(tag, cnt, exp_cnt);
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, "_valid_low"}, out_valid, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  logic [31:0] sip_a, dip_a, full_set;
  int          seen;

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sip_set   = '0;
    dip_set   = '0;
    do_reset();

    // Reset state
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_set", out_set, 32'h0);
    check("rst_out_hit", out_hit, 1'b0);
    check("rst_best_id", out_best_id, 3'd0);
    check("rst_fmt_err", out_fmt_err, 1'b0);

    // SIP {2,5,6,7} in slots 4..7, DIP {0,5,7} in slots 5..7 -> {5,7}
    sip_a = mk(8'b0000_1111, {3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd5, 3'd6, 3'd7});
    dip_a = mk(8'b0000_0111, {3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5, 3'd7});
    send(sip_a, dip_a);
    wait_out("a_latency", 10);
    check("a_out_set", out_set, mk(8'b1100_0000, {3'd5, 3'd7, 18'd0}));
    check("a_out_hit", out_hit, 1'b1);
    check("a_best_id", out_best_id, 3'd5);
    release_out("a");

    // Disjoint {1,3} vs {2,4}; in_valid held high with junk during merge
    full_set = mk(8'hFF, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7});
    send(mk(8'b1100_0000, {3'd1, 3'd3, 18'd0}), mk(8'b1100_0000, {3'd2, 3'd4, 18'd0}));
    sip_set  = full_set;
    dip_set  = full_set;
    in_valid = 1'b1;
    wait_out("b_latency", 9);
    in_valid = 1'b0;
    check("b_out_set", out_set, 32'h0);
    check("b_out_hit", out_hit, 1'b0);
    check("b_best_id", out_best_id, 3'd0);
    release_out("b");

    // Identical full sets: 8-cycle merge, all IDs out; then backpressure
    send(full_set, full_set);
    wait_out("c_latency", 8);
    check("c_out_set", out_set, full_set);
    check("c_out_hit", out_hit, 1'b1);
    check("c_best_id", out_best_id, 3'd0);
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      @(negedge clk);
      check("hold_out_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
      check("hold_out_set", out_set, full_set);
      check("hold_out_hit", out_hit, 1'b1);
    end
    release_out("c");

    // Reset on the third MERGE cycle discards the pair
    send(sip_a, dip_a);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mrst_in_ready", in_ready, 1'b1);
    check("mrst_out_valid", out_valid, 1'b0);
    check("mrst_out_set", out_set, 32'h0);
    check("mrst_out_hit", out_hit, 1'b0);
    seen = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mrst_no_result", seen, 0);

`ifdef RULE_SET_FORMAT_CHECK_EN
    // SIP slots 6,7 hold 5,3: sticky error, merge still completes
    send(mk(8'b0000_0011, {18'd0, 3'd5, 3'd3}), mk(8'b0000_0001, {21'd0, 3'd3}));
    @(negedge clk);
    check("fmt_set", out_fmt_err, 1'b1);
    wait_out("fmt_latency", 8);
    check("fmt_out_hit", out_hit, 1'b0);
    release_out("fmt");
    send(full_set, full_set);
    wait_out("fmt_good_latency", 8);
    check("fmt_sticky", out_fmt_err, 1'b1);
    release_out("fmt_good");
    do_reset();
    @(negedge clk);
    check("fmt_cleared", out_fmt_err, 1'b0);
`else
    send(mk(8'b0000_0011, {18'd0, 3'd5, 3'd3}), mk(8'b0000_0001, {21'd0, 3'd3}));
    wait_out("nofmt_latency", 8);
    check("nofmt_tied", out_fmt_err, 1'b0);
    release_out("nofmt");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rule_set_intersect.md
RULE_SET_INTERSECT -- requirements
Module: rule_set_intersect

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is positive-edge triggered.
REQ-002 The block SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The block SHALL have the port in_valid, input, 1 bit: the SIP/DIP set pair is presented.
REQ-004 The block SHALL have the port in_ready, output, 1 bit: the block can accept a set pair.
REQ-005 The block SHALL have the port sip_set, input, 32 bits [0:31]: the SIP rule ID set from the SIP prefix match tree.
REQ-006 The block SHALL have the port dip_set, input, 32 bits [0:31]: the DIP rule ID set, in the same format as sip_set.
REQ-007 The block SHALL have the port out_valid, output, 1 bit: the result is valid.
REQ-008 The block SHALL have the port out_ready, input, 1 bit: the downstream stage accepts the result.
REQ-009 The block SHALL have the port out_set, output, 32 bits [0:31]: the intersection of the two sets, in the rule ID set format.
REQ-010 The block SHALL have the port out_hit, output, 1 bit: at least one rule is common to both sets.
REQ-011 The block SHALL have the port out_best_id, output, 3 bits: the lowest common rule ID, which is the highest-priority rule.
REQ-012 The block SHALL have the port out_fmt_err, output, 1 bit: a sticky input-format error flag (see Configuration).
REQ-013 The rule ID set format SHALL be: bits [0:7] hold valid bits v[k] for slots 0..7; bits [8+3k : 10+3k] hold the ID of slot k, MSB first.
REQ-014 The IDs of the valid slots SHALL be strictly ascending in slot order; invalid slots may be interleaved anywhere.

Function
REQ-015 The FSM SHALL have three states: IDLE, MERGE and DONE.
REQ-016 In IDLE, in_ready SHALL be 1; in every other state, in_ready SHALL be 0.
REQ-017 On in_valid && in_ready, the block SHALL latch both sets, clear the 4-bit pointers i and j and the output count k, clear out_set, and go to MERGE.
REQ-018 Each MERGE cycle SHALL perform exactly one step, evaluated in this order:
- If sip slot i is invalid or dip slot j is invalid, advance each pointer whose slot is invalid.
- Otherwise, if the IDs are equal, write that ID into out_set slot k with its valid bit set, then increment k, i and j.
- Otherwise, advance only the pointer whose slot holds the smaller ID.
REQ-019 When a step leaves i==8 or j==8, the next state SHALL be DONE.
REQ-020 A MERGE phase SHALL take 8 to 15 cycles; out_valid SHALL rise on the cycle after the terminating step.
REQ-021 Intersection results SHALL be packed into slots 0..k-1 in ascending order; unused slots SHALL have valid 0 and ID 000.
REQ-022 out_hit SHALL equal (k != 0).
REQ-023 out_best_id SHALL equal the slot 0 ID when out_hit is 1, and 000 otherwise.
REQ-024 In DONE, out_valid SHALL be 1 and all outputs SHALL hold stable until out_ready is 1.
REQ-025 On out_valid && out_ready, the block SHALL return to IDLE with out_valid 0 on the next cycle.
REQ-026 in_valid asserted outside IDLE SHALL be ignored; the upstream stage must hold its data until in_ready is 1.

Reset
REQ-027 reset SHALL force IDLE and set in_ready=1, out_valid=0, out_set=0, out_hit=0, out_best_id=000 and out_fmt_err=0.
REQ-028 reset SHALL clear i, j and k.
REQ-029 A reset asserted during MERGE or DONE SHALL discard the pending pair with no result emitted.
REQ-030 reset SHALL take priority over a simultaneous input or output handshake.

Configuration
REQ-031 The macro RULE_SET_FORMAT_CHECK_EN SHALL select whether format checking is compiled in.
REQ-032 With RULE_SET_FORMAT_CHECK_EN defined, the block SHALL check, at acceptance, whether the valid IDs of either input set are not strictly ascending; a violation SHALL set out_fmt_err, which stays 1 until reset, and merging SHALL proceed unchanged.
REQ-033 Without RULE_SET_FORMAT_CHECK_EN, out_fmt_err SHALL be tied to 0 and no check logic SHALL be present.

Verification
REQ-034 Bench SHALL drive SIP valid IDs {2,5,6,7} in slots 4..7 and DIP IDs {0,5,7} in slots 5..7 -> out_set holds slot0=5 and slot1=7, out_hit=1, out_best_id=5.
REQ-035 Bench SHALL drive disjoint sets {1,3} and {2,4} -> out_hit=0, out_set=32'h0, out_best_id=0.
REQ-036 Bench SHALL drive two identical full sets {0..7} -> out_valid rises 8 cycles after acceptance, and out_set contains all 8 IDs with valid bits 8'hFF.
REQ-037 Bench SHALL hold out_ready=0 for 5 cycles in DONE -> outputs remain stable and in_ready stays 0; after out_ready=1, in_ready=1 on the next cycle.
REQ-038 Bench SHALL assert reset on the 3rd MERGE cycle -> next cycle in IDLE with out_valid=0, and no result appears for the discarded pair.
REQ-039 With RULE_SET_FORMAT_CHECK_EN defined, bench SHALL drive a SIP set with slots 6,7 holding IDs 5,3 -> out_fmt_err=1 and stays 1 across later good pairs until reset.
